// File: rtl/mc_alu_if.sv
// ---------------------------------------------------------------------------
// mc_alu_if
// Handshake and data bundle between a sequencer (master) and the multi-cycle
// ALU (slave).
//   start_in   master->slave  launch an op (taken only while busy_out==0)
//   op_in      master->slave  4-bit opcode
//   din_a      master->slave  operand A (shift source, dividend)
//   din_b      master->slave  operand B (shift distance, divisor)
//   cin, vin   master->slave  incoming carry / overflow flags
//   busy_out   slave->master  multi-cycle op in progress
//   valid_out  slave->master  one-cycle pulse: a new result is on dout/flags
//   dout       slave->master  result, held until the next result
//   cout, vout slave->master  carry / overflow out, held
//   divz_out   slave->master  last result was a divide by zero, held
// ---------------------------------------------------------------------------
interface mc_alu_if #(
  parameter int WIDTH = 32
);
  logic             start_in;
  logic [3:0]       op_in;
  logic [WIDTH-1:0] din_a;
  logic [WIDTH-1:0] din_b;
  logic             cin;
  logic             vin;
  logic             busy_out;
  logic             valid_out;
  logic [WIDTH-1:0] dout;
  logic             cout;
  logic             vout;
  logic             divz_out;

  modport master (
    output start_in, op_in, din_a, din_b, cin, vin,
    input  busy_out, valid_out, dout, cout, vout, divz_out
  );

  modport slave (
    input  start_in, op_in, din_a, din_b, cin, vin,
    output busy_out, valid_out, dout, cout, vout, divz_out
  );
endinterface

// File: rtl/mc_alu.sv
// ---------------------------------------------------------------------------
// mc_alu
// Multi-cycle ALU: single-cycle logic/add/sub/shift/rotate ops, an iterative
// multiplier retiring MUL_BPC multiplier bits per cycle, and an optional
// restoring unsigned divider (1 quotient bit per cycle).
//
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-high; abandons any op in flight
//   bus    mc_alu_if.slave (start/op/operands/flags in, busy/valid/result out)
//
// Parameters
//   WIDTH    datapath width (power of 2, >= 8)
//   MUL_BPC  multiplier bits per cycle (power of 2, divides WIDTH)
//
// Build option
//   MCALU_DIV_EN  when defined, DIVU/MODU use the iterative divider (DIV
//                 state). When undefined the divider is absent, DIVU/MODU
//                 behave as MOV and divz_out is tied 0.
// ---------------------------------------------------------------------------
module mc_alu #(
  parameter int WIDTH   = 32,
  parameter int MUL_BPC = 2
) (
  input logic     clk,
  input logic     reset,
  mc_alu_if.slave bus
);

  localparam int LOG2W     = $clog2(WIDTH);
  localparam int MUL_STEPS = WIDTH / MUL_BPC;

  localparam logic [LOG2W-1:0] D_ZERO   = {LOG2W{1'b0}};
  localparam logic [LOG2W-1:0] D_ONE    = {{(LOG2W-1){1'b0}}, 1'b1};
  localparam logic [LOG2W-1:0] MUL_LAST = LOG2W'(MUL_STEPS - 1);

  localparam logic [3:0] OP_MOV = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_ASR = 4'd6;
  localparam logic [3:0] OP_LSR = 4'd7;
  localparam logic [3:0] OP_ROR = 4'd8;
  localparam logic [3:0] OP_ASL = 4'd9;
  localparam logic [3:0] OP_ROL = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;
`ifdef MCALU_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'd12;
  localparam logic [3:0] OP_MODU = 4'd13;
  localparam logic [LOG2W-1:0] DIV_LAST = LOG2W'(WIDTH - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1
`ifdef MCALU_DIV_EN
    , ST_DIV = 2'd2
`endif
  } state_t;

  state_t             state_r;
  logic               busy_r;
  logic               valid_r;
  logic [WIDTH-1:0]   dout_r;
  logic               cout_r;
  logic               vout_r;
  logic [LOG2W-1:0]   cnt_r;

  // multiplier state: shifted multiplicand, remaining multiplier bits, product
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] pp_s;
  logic [2*WIDTH-1:0] acc_next_s;

  // single-cycle datapath
  logic [WIDTH-1:0]   a_s;
  logic [WIDTH-1:0]   b_s;
  logic [WIDTH-1:0]   res_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     dif_s;
  logic [LOG2W-1:0]   d_s;
  logic [LOG2W-1:0]   dm1_s;
  logic [LOG2W-1:0]   dinv_s;
  logic               c_s;
  logic               v_s;
  logic               go_mul_s;

`ifdef MCALU_DIV_EN
  logic               divz_r;
  logic               z_s;
  logic               go_div_s;
  logic [WIDTH-1:0]   quot_r;
  logic [WIDTH-1:0]   rem_r;
  logic [WIDTH-1:0]   divisor_r;
  logic               is_mod_r;
  logic [WIDTH:0]     rem_sh_s;
  logic [WIDTH+1:0]   trial_s;
  logic [WIDTH-1:0]   rem_next_s;
  logic [WIDTH-1:0]   quot_next_s;
`endif

  // Single-cycle result and flags, plus long-op launch decode, from live inputs
  always_comb begin
    a_s      = bus.din_a;
    b_s      = bus.din_b;
    d_s      = b_s[LOG2W-1:0];
    dm1_s    = d_s - D_ONE;
    // WIDTH - d modulo WIDTH; only used when d != 0
    dinv_s   = D_ZERO - d_s;
    sum_s    = {1'b0, a_s} + {1'b0, b_s};
    dif_s    = {1'b0, a_s} - {1'b0, b_s};
    res_s    = b_s;
    c_s      = bus.cin;
    v_s      = bus.vin;
    go_mul_s = 1'b0;
`ifdef MCALU_DIV_EN
    z_s      = 1'b0;
    go_div_s = 1'b0;
`endif
    case (bus.op_in)
      OP_MOV: res_s = b_s;
      OP_AND: begin res_s = a_s & b_s; c_s = 1'b0; end
      OP_OR:  begin res_s = a_s | b_s; c_s = 1'b0; end
      OP_XOR: begin res_s = a_s ^ b_s; c_s = 1'b0; end
      OP_ADD: begin
        res_s = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        v_s   = (a_s[WIDTH-1] == b_s[WIDTH-1]) && (sum_s[WIDTH-1] != a_s[WIDTH-1]);
      end
      OP_SUB: begin
        res_s = dif_s[WIDTH-1:0];
        c_s   = dif_s[WIDTH];  // borrow
        v_s   = (a_s[WIDTH-1] != b_s[WIDTH-1]) && (dif_s[WIDTH-1] != a_s[WIDTH-1]);
      end
      OP_ASR, OP_LSR, OP_ROR, OP_ASL, OP_ROL: begin
        if (d_s == D_ZERO) begin
          res_s = a_s;
          c_s   = bus.cin;
        end else begin
          case (bus.op_in)
            OP_ASR:  begin res_s = $unsigned($signed(a_s) >>> d_s); c_s = a_s[dm1_s]; end
            OP_LSR:  begin res_s = a_s >> d_s; c_s = a_s[dm1_s]; end
            OP_ROR:  begin res_s = (a_s >> d_s) | (a_s << dinv_s); c_s = a_s[dm1_s]; end
            OP_ASL:  begin res_s = a_s << d_s; c_s = a_s[dinv_s]; end
            OP_ROL:  begin res_s = (a_s << d_s) | (a_s >> dinv_s); c_s = a_s[dinv_s]; end
            default: begin res_s = a_s; c_s = bus.cin; end
          endcase
        end
      end
      OP_MUL: go_mul_s = 1'b1;
`ifdef MCALU_DIV_EN
      OP_DIVU, OP_MODU: begin
        if (b_s == {WIDTH{1'b0}}) begin
          // divide by zero finishes immediately without iterating
          z_s   = 1'b1;
          c_s   = 1'b0;
          res_s = (bus.op_in == OP_DIVU) ? {WIDTH{1'b1}} : a_s;
        end else begin
          go_div_s = 1'b1;
        end
      end
`endif
      default: res_s = b_s;  // 14/15 (and DIVU/MODU without divider) act as MOV
    endcase
  end

  // One multiplier step: add MUL_BPC shifted copies of the multiplicand
  always_comb begin
    pp_s = {(2*WIDTH){1'b0}};
    for (int i = 0; i < MUL_BPC; i++) begin
      pp_s = pp_s + ((mcand_r << i) & {(2*WIDTH){mplier_r[i]}});
    end
    acc_next_s = acc_r + pp_s;
  end

`ifdef MCALU_DIV_EN
  // One restoring-divide step: shift in next dividend bit, trial-subtract
  always_comb begin
    rem_sh_s = {rem_r, quot_r[WIDTH-1]};
    trial_s  = {1'b0, rem_sh_s} - {2'b00, divisor_r};
    if (trial_s[WIDTH+1]) begin
      rem_next_s = rem_sh_s[WIDTH-1:0];
    end else begin
      rem_next_s = trial_s[WIDTH-1:0];
    end
    quot_next_s = {quot_r[WIDTH-2:0], ~trial_s[WIDTH+1]};
  end
`endif

  // Control FSM, iteration registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
      dout_r   <= {WIDTH{1'b0}};
      cout_r   <= 1'b0;
      vout_r   <= 1'b0;
      cnt_r    <= D_ZERO;
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
`ifdef MCALU_DIV_EN
      divz_r    <= 1'b0;
      quot_r    <= {WIDTH{1'b0}};
      rem_r     <= {WIDTH{1'b0}};
      divisor_r <= {WIDTH{1'b0}};
      is_mod_r  <= 1'b0;
`endif
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start_in) begin
            cnt_r <= D_ZERO;
            if (go_mul_s) begin
              state_r  <= ST_MUL;
              busy_r   <= 1'b1;
              mcand_r  <= {{WIDTH{1'b0}}, bus.din_a};
              mplier_r <= bus.din_b;
              acc_r    <= {(2*WIDTH){1'b0}};
`ifdef MCALU_DIV_EN
            end else if (go_div_s) begin
              state_r   <= ST_DIV;
              busy_r    <= 1'b1;
              quot_r    <= bus.din_a;
              rem_r     <= {WIDTH{1'b0}};
              divisor_r <= bus.din_b;
              is_mod_r  <= (bus.op_in == OP_MODU);
`endif
            end else begin
              valid_r <= 1'b1;
              dout_r  <= res_s;
              cout_r  <= c_s;
              vout_r  <= v_s;
`ifdef MCALU_DIV_EN
              divz_r  <= z_s;
`endif
            end
          end
        end
        ST_MUL: begin
          acc_r    <= acc_next_s;
          mcand_r  <= mcand_r << MUL_BPC;
          mplier_r <= mplier_r >> MUL_BPC;
          cnt_r    <= cnt_r + D_ONE;
          if (cnt_r == MUL_LAST) begin
            // busy drops with valid so a new start can be taken this cycle
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            valid_r <= 1'b1;
            dout_r  <= acc_next_s[WIDTH-1:0];
            cout_r  <= 1'b0;
            vout_r  <= |acc_next_s[2*WIDTH-1:WIDTH];
`ifdef MCALU_DIV_EN
            divz_r  <= 1'b0;
`endif
          end
        end
`ifdef MCALU_DIV_EN
        ST_DIV: begin
          quot_r <= quot_next_s;
          rem_r  <= rem_next_s;
          cnt_r  <= cnt_r + D_ONE;
          if (cnt_r == DIV_LAST) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            valid_r <= 1'b1;
            dout_r  <= is_mod_r ? rem_next_s : quot_next_s;
            cout_r  <= 1'b0;
            vout_r  <= 1'b0;
            divz_r  <= 1'b0;
          end
        end
`endif
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_out  = busy_r;
  assign bus.valid_out = valid_r;
  assign bus.dout      = dout_r;
  assign bus.cout      = cout_r;
  assign bus.vout      = vout_r;
`ifdef MCALU_DIV_EN
  assign bus.divz_out  = divz_r;
`else
  assign bus.divz_out  = 1'b0;
`endif

endmodule

// File: tb/tb_mc_alu.sv
`timescale 1ns/1ps
module tb_mc_alu;
  localparam int W     = 32;
  localparam int BPC   = 2;
  localparam int NSTEP = W / BPC;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  mc_alu_if #(.WIDTH(W)) bus ();
  mc_alu #(.WIDTH(W), .MUL_BPC(BPC)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        c;
    logic        v;
    logic        z;
    int          lat;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        vi;
    logic [31:0] d;
    logic        c;
    logic        v;
    logic        z;
    int          lat;
  } dir_t;

  // Reference model from the arithmetic rules; lat is cycles from accept to valid
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic vi);
    exp_t   e;
    int     sh;
    longint sa, sb, t;
    logic [63:0] w;
    sh = int'(b[4:0]);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.d = b; e.c = ci; e.v = vi; e.z = 1'b0; e.lat = 1;
    case (op)
      4'd1: begin e.d = a & b; e.c = 1'b0; end
      4'd2: begin e.d = a | b; e.c = 1'b0; end
      4'd3: begin e.d = a ^ b; e.c = 1'b0; end
      4'd4: begin
        w = {32'h0, a} + {32'h0, b}; e.d = w[31:0]; e.c = w[32];
        t = sa + sb; e.v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'd5: begin
        e.d = a - b; e.c = (a < b);
        t = sa - sb; e.v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'd6, 4'd7, 4'd8, 4'd9, 4'd10: begin
        if (sh == 0) begin
          e.d = a;
        end else begin
          case (op)
            4'd6: begin e.d = $unsigned($signed(a) >>> sh); w = {32'h0, a}; e.c = w[sh-1]; end
            4'd7: begin e.d = a >> sh; w = {32'h0, a}; e.c = w[sh-1]; end
            4'd8: begin w = {a, a} >> sh; e.d = w[31:0]; e.c = e.d[31]; end
            4'd9: begin w = {32'h0, a} << sh; e.d = w[31:0]; e.c = w[32]; end
            default: begin w = {a, a} << sh; e.d = w[63:32]; e.c = e.d[0]; end
          endcase
        end
      end
      4'd11: begin
        w = {32'h0, a} * {32'h0, b};
        e.d = w[31:0]; e.c = 1'b0; e.v = (w[63:32] != 32'h0); e.lat = NSTEP + 1;
      end
`ifdef MCALU_DIV_EN
      4'd12, 4'd13: begin
        e.c = 1'b0;
        if (b == 32'h0) begin
          e.z = 1'b1;
          e.d = (op == 4'd12) ? 32'hFFFF_FFFF : a;
        end else begin
          e.v = 1'b0;
          e.d = (op == 4'd12) ? a / b : a % b;
          e.lat = W + 1;
        end
      end
`endif
      default: e.d = b;
    endcase
    return e;
  endfunction

  // Launch one op, scramble inputs and pulse start while busy, wait for valid
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic vi, output int lat, output int busy_cnt,
                       output logic vld, output logic bz, output logic [31:0] d,
                       output logic c, output logic v, output logic z);
    @(negedge clk);
    bus.start_in = 1'b1; bus.op_in = op; bus.din_a = a; bus.din_b = b; bus.cin = ci; bus.vin = vi;
    @(negedge clk);
    lat = 1; busy_cnt = 0;
    while (bus.valid_out !== 1'b1 && lat < 100) begin
      if (bus.busy_out === 1'b1) busy_cnt++;
      bus.start_in = 1'($urandom_range(0, 1));
      bus.op_in = 4'($urandom); bus.din_a = $urandom; bus.din_b = $urandom;
      bus.cin = 1'($urandom); bus.vin = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    bus.start_in = 1'b0;
    vld = bus.valid_out; bz = bus.busy_out; d = bus.dout;
    c = bus.cout; v = bus.vout; z = bus.divz_out;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.busy_out, bus.valid_out, bus.dout, bus.cout, bus.vout, bus.divz_out} !== 36'h0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b valid=%b dout=%h c=%b v=%b z=%b, want all 0",
               bus.busy_out, bus.valid_out, bus.dout, bus.cout, bus.vout, bus.divz_out);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.busy_out, bus.valid_out, bus.dout} !== 34'h0) begin
      n_err++;
      $display("FAIL idle_after_reset: got busy=%b valid=%b dout=%h, want 0 0 0",
               bus.busy_out, bus.valid_out, bus.dout);
    end
  endtask

  task automatic test_directed();
    dir_t tbl[$];
    int lat, bc;
    logic vld, bz, c, v, z;
    logic [31:0] d;
    tbl.push_back('{4'd4,  32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1});
    tbl.push_back('{4'd6,  32'h8000_0010, 32'h4,         1'b1, 1'b0, 32'hF800_0001, 1'b0, 1'b0, 1'b0, 1});
    tbl.push_back('{4'd10, 32'h8000_0001, 32'h1,         1'b0, 1'b1, 32'h0000_0003, 1'b1, 1'b1, 1'b0, 1});
    tbl.push_back('{4'd7,  32'h1234_5678, 32'h0,         1'b1, 1'b0, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1});
    tbl.push_back('{4'd11, 32'h0001_2345, 32'h0001_0000, 1'b1, 1'b0, 32'h2345_0000, 1'b0, 1'b1, 1'b0, 17});
    tbl.push_back('{4'd5,  32'h0,         32'h1,         1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1});
    tbl.push_back('{4'd5,  32'h8000_0000, 32'h1,         1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1});
`ifdef MCALU_DIV_EN
    tbl.push_back('{4'd12, 32'd100,       32'd7,         1'b1, 1'b1, 32'd14,        1'b0, 1'b0, 1'b0, 33});
    tbl.push_back('{4'd13, 32'd100,       32'd7,         1'b1, 1'b1, 32'd2,         1'b0, 1'b0, 1'b0, 33});
    tbl.push_back('{4'd12, 32'd5,         32'd0,         1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1});
    tbl.push_back('{4'd4,  32'd1,         32'd2,         1'b1, 1'b1, 32'd3,         1'b0, 1'b0, 1'b0, 1});
`else
    tbl.push_back('{4'd12, 32'd5,         32'd9,         1'b1, 1'b1, 32'd9,         1'b1, 1'b1, 1'b0, 1});
    tbl.push_back('{4'd13, 32'd7,         32'd3,         1'b0, 1'b0, 32'd3,         1'b0, 1'b0, 1'b0, 1});
`endif
    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].vi, lat, bc, vld, bz, d, c, v, z);
      n_vec++;
      if ({vld, bz, d, c, v, z} !== {1'b1, 1'b0, tbl[i].d, tbl[i].c, tbl[i].v, tbl[i].z}) begin
        n_err++;
        $display("FAIL directed_%0d op=%0d: got valid=%b busy=%b d=%h c=%b v=%b z=%b, want d=%h c=%b v=%b z=%b",
                 i, tbl[i].op, vld, bz, d, c, v, z, tbl[i].d, tbl[i].c, tbl[i].v, tbl[i].z);
      end
      n_vec++;
      if (lat != tbl[i].lat || bc != tbl[i].lat - 1) begin
        n_err++;
        $display("FAIL directed_lat_%0d op=%0d: got latency=%0d busy_cycles=%0d, want %0d and %0d",
                 i, tbl[i].op, lat, bc, tbl[i].lat, tbl[i].lat - 1);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [31:0] a, b;
    logic ci, vi, vld, bz, c, v, z;
    logic [31:0] d;
    int lat, bc;
    exp_t e;
    for (int k = 0; k < 150; k++) begin
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 7))
        0: a = 32'h0;
        1: a = 32'h8000_0000;
        2: a = 32'h7FFF_FFFF;
        3: a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = $urandom_range(1, 15);
        2: b = 32'h1;
        3: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      ci = 1'($urandom); vi = 1'($urandom);
      e = model(op, a, b, ci, vi);
      issue(op, a, b, ci, vi, lat, bc, vld, bz, d, c, v, z);
      n_vec++;
      if ({vld, bz, d, c, v, z} !== {1'b1, 1'b0, e.d, e.c, e.v, e.z} || lat != e.lat || bc != e.lat - 1) begin
        n_err++;
        $display("FAIL random_%0d op=%0d a=%h b=%h ci=%b vi=%b: got valid=%b busy=%b d=%h c=%b v=%b z=%b lat=%0d busy_cyc=%0d, want d=%h c=%b v=%b z=%b lat=%0d",
                 k, op, a, b, ci, vi, vld, bz, d, c, v, z, lat, bc, e.d, e.c, e.v, e.z, e.lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t q[$];
    exp_t e;
    logic [3:0] op;
    logic [31:0] a, b;
    int r, waited;
    @(negedge clk);
    for (int k = 0; k <= 24; k++) begin
      if (k > 0) begin
        e = q.pop_front();
        n_vec++;
        if ({bus.valid_out, bus.busy_out, bus.dout, bus.cout, bus.vout, bus.divz_out} !==
            {1'b1, 1'b0, e.d, e.c, e.v, e.z}) begin
          n_err++;
          $display("FAIL b2b_%0d: got valid=%b busy=%b d=%h c=%b v=%b z=%b, want valid=1 busy=0 d=%h c=%b v=%b z=%b",
                   k, bus.valid_out, bus.busy_out, bus.dout, bus.cout, bus.vout, bus.divz_out, e.d, e.c, e.v, e.z);
        end
      end
      if (k < 24) begin
        r = $urandom_range(0, 12);
        op = (r <= 10) ? 4'(r) : 4'(r + 3);
        bus.start_in = 1'b1; bus.op_in = op; bus.din_a = $urandom; bus.din_b = $urandom;
        bus.cin = 1'($urandom); bus.vin = 1'($urandom);
        q.push_back(model(op, bus.din_a, bus.din_b, bus.cin, bus.vin));
      end else begin
        bus.start_in = 1'b0;
      end
      @(negedge clk);
    end
    // MUL, then a new op launched in the very cycle its result appears
    a = $urandom; b = $urandom;
    bus.start_in = 1'b1; bus.op_in = 4'd11; bus.din_a = a; bus.din_b = b;
    @(negedge clk);
    bus.start_in = 1'b0;
    waited = 1;
    while (bus.valid_out !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    e = model(4'd11, a, b, 1'b0, 1'b0);
    n_vec++;
    if (bus.valid_out !== 1'b1 || bus.busy_out !== 1'b0 || bus.dout !== e.d || waited != e.lat) begin
      n_err++;
      $display("FAIL mul_then_start: got valid=%b busy=%b d=%h lat=%0d, want valid=1 busy=0 d=%h lat=%0d",
               bus.valid_out, bus.busy_out, bus.dout, waited, e.d, e.lat);
    end
    a = $urandom; b = $urandom;
    bus.start_in = 1'b1; bus.op_in = 4'd4; bus.din_a = a; bus.din_b = b; bus.cin = 1'b0; bus.vin = 1'b0;
    @(negedge clk);
    bus.start_in = 1'b0;
    e = model(4'd4, a, b, 1'b0, 1'b0);
    n_vec++;
    if (bus.valid_out !== 1'b1 || {bus.dout, bus.cout, bus.vout} !== {e.d, e.c, e.v}) begin
      n_err++;
      $display("FAIL start_at_valid: got valid=%b d=%h c=%b v=%b, want valid=1 d=%h c=%b v=%b",
               bus.valid_out, bus.dout, bus.cout, bus.vout, e.d, e.c, e.v);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [3:0] long_op;
    logic [31:0] a, b, d;
    logic vld, bz, c, v, z;
    int lat, bc;
    bit seen;
    exp_t e;
`ifdef MCALU_DIV_EN
    long_op = 4'd12;
`else
    long_op = 4'd11;
`endif
    issue(4'd4, 32'h11, 32'h22, 1'b1, 1'b1, lat, bc, vld, bz, d, c, v, z);
    @(negedge clk);
    bus.start_in = 1'b1; bus.op_in = long_op; bus.din_a = 32'd1000; bus.din_b = 32'd3;
    @(negedge clk);
    bus.start_in = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++;
    if (bus.busy_out !== 1'b1 || bus.dout !== 32'h33) begin
      n_err++;
      $display("FAIL busy_before_reset: got busy=%b dout=%h, want busy=1 dout=00000033", bus.busy_out, bus.dout);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if ({bus.busy_out, bus.valid_out, bus.dout, bus.cout, bus.vout, bus.divz_out} !== 36'h0) begin
      n_err++;
      $display("FAIL reset_mid_op: got busy=%b valid=%b dout=%h c=%b v=%b z=%b, want all 0",
               bus.busy_out, bus.valid_out, bus.dout, bus.cout, bus.vout, bus.divz_out);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.valid_out === 1'b1 || bus.busy_out === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (seen) begin
      n_err++;
      $display("FAIL late_valid_after_reset: got activity=1, want 0");
    end
    a = $urandom; b = $urandom;
    e = model(4'd5, a, b, 1'b1, 1'b0);
    issue(4'd5, a, b, 1'b1, 1'b0, lat, bc, vld, bz, d, c, v, z);
    n_vec++;
    if ({vld, d, c, v, z} !== {1'b1, e.d, e.c, e.v, e.z} || lat != 1) begin
      n_err++;
      $display("FAIL op_after_reset: got valid=%b d=%h c=%b v=%b z=%b lat=%0d, want d=%h c=%b v=%b z=%b lat=1",
               vld, d, c, v, z, lat, e.d, e.c, e.v, e.z);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start_in = 1'b0; bus.op_in = 4'd0; bus.din_a = 32'h0; bus.din_b = 32'h0;
    bus.cin = 1'b0; bus.vin = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
